// File: rtl/matriz_pkg.sv
// Shared definitions for the sequential matrix add/sub unit: op codes, FSM states,
// beat count and saturation bounds.
package matriz_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    // Number of beats needed to cover n*n elements at lanes elements per beat
    function automatic int unsigned beatsOf(input int unsigned n, input int unsigned lanes);
        return (n * n + lanes - 1) / lanes;
    endfunction

    function automatic int satMax(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int satMin(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/matriz_addsub_seq_if.sv
// Operand/result bus between the coprocessor control FSM (master) and matriz_addsub_seq (slave).
interface matriz_addsub_seq_if #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 8
);
    logic                 start;
    logic                 op;
    logic [N*N*W-1:0]     matrizA;
    logic [N*N*W-1:0]     matrizB;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [N*N*W-1:0]     matriz_resultante;

    modport master (
        output start, op, matrizA, matrizB,
        input  busy, done, overflow, matriz_resultante
    );

    modport slave (
        input  start, op, matrizA, matrizB,
        output busy, done, overflow, matriz_resultante
    );
endinterface

// File: rtl/matriz_lane_alu.sv
// One W-bit signed add/sub lane with overflow detect.
// MATRIZ_SAT_EN selects clamping of overflowed results; otherwise results wrap modulo 2^W.
module matriz_lane_alu
    import matriz_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    input  logic         en,
    output logic [W-1:0] resC,
    output logic         ovfC
);

`ifdef MATRIZ_SAT_EN
    localparam logic [W-1:0] MAXV = W'(satMax(W));
    localparam logic [W-1:0] MINV = W'(satMin(W));
`endif

    logic [W:0] full;
    logic       rawOvf;

    // Sign-extend to W+1 bits; overflow when the two top bits disagree
    always_comb begin
        full = '0;
        if (op == OP_SUB) begin
            full = {a[W-1], a} - {b[W-1], b};
        end else begin
            full = {a[W-1], a} + {b[W-1], b};
        end
        rawOvf = full[W] ^ full[W-1];
`ifdef MATRIZ_SAT_EN
        if (rawOvf) begin
            resC = full[W] ? MINV : MAXV;
        end else begin
            resC = full[W-1:0];
        end
`else
        resC = full[W-1:0];
`endif
        ovfC = en & rawOvf;
    end

endmodule

// File: rtl/matriz_addsub_seq.sv
// Sequential element-wise matrix add/sub, LANES elements per beat, one-cycle done pulse.
// Optional MATRIZ_SAT_EN (in matriz_lane_alu) saturates overflowed elements.
module matriz_addsub_seq
    import matriz_pkg::*;
#(
    parameter int unsigned N     = 5,
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 5
) (
    input  logic           clk,
    input  logic           reset,
    matriz_addsub_seq_if.slave bus
);

    localparam int unsigned NE    = N * N;
    localparam int unsigned VW    = NE * W;
    localparam int unsigned BEATS = beatsOf(N, LANES);
    localparam int unsigned IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned AW    = (VW > 1) ? $clog2(VW) : 1;

    stateT           state;
    logic [IDXW-1:0] idx;
    logic            opR;
    logic [VW-1:0]   regA;
    logic [VW-1:0]   regB;
    logic            busyR;
    logic            doneR;
    logic            ovfR;
    logic [W-1:0]    resArr [NE];

    logic [W-1:0]     laneA   [LANES];
    logic [W-1:0]     laneB   [LANES];
    logic [W-1:0]     laneRes [LANES];
    logic [LANES-1:0] laneEn;
    logic [LANES-1:0] laneOvf;
    int unsigned      ei;
    int unsigned      sel;

    // Route the current beat's operand elements to each lane; lanes past the last element idle
    always_comb begin
        laneEn = '0;
        ei     = 0;
        sel    = 0;
        for (int unsigned l = 0; l < LANES; l++) begin
            ei        = 32'(idx) * LANES + l;
            laneEn[l] = (state == RUN) && (ei < NE);
            sel       = (ei < NE) ? ei : 0;
            laneA[l]  = regA[AW'(sel * W) +: W];
            laneB[l]  = regB[AW'(sel * W) +: W];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gLane
        matriz_lane_alu #(.W(W)) uAlu (
            .a    (laneA[g]),
            .b    (laneB[g]),
            .op   (opR),
            .en   (laneEn[g]),
            .resC (laneRes[g]),
            .ovfC (laneOvf[g])
        );
    end

    // Each result element is owned by a fixed (beat, lane) pair
    for (genvar e = 0; e < NE; e++) begin : gElem
        localparam int unsigned BEAT = e / LANES;
        localparam int unsigned LANE = e % LANES;

        always_ff @(posedge clk) begin
            if (reset) begin
                resArr[e] <= '0;
            end else if (state == RUN && idx == IDXW'(BEAT)) begin
                resArr[e] <= laneRes[LANE];
            end
        end

        assign bus.matriz_resultante[e*W +: W] = resArr[e];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            opR   <= OP_ADD;
            regA  <= '0;
            regB  <= '0;
            busyR <= 1'b0;
            doneR <= 1'b0;
            ovfR  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doneR <= 1'b0;
                    if (bus.start) begin
                        regA  <= bus.matrizA;
                        regB  <= bus.matrizB;
                        opR   <= bus.op;
                        ovfR  <= 1'b0;
                        idx   <= '0;
                        busyR <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ovfR <= ovfR | (|laneOvf);
                    if (idx == IDXW'(BEATS - 1)) begin
                        idx   <= '0;
                        busyR <= 1'b0;
                        doneR <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    doneR <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busyR <= 1'b0;
                    doneR <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busyR;
    assign bus.done     = doneR;
    assign bus.overflow = ovfR;

endmodule

// File: tb/tb_matriz_addsub_seq.sv
// Self-checking bench for matriz_addsub_seq: per-cycle compare against a behavioural model,
// directed literal checks, and a second N=3/LANES=4 instance.
module tb_matriz_addsub_seq;
    import matriz_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned N0  = 5;
    localparam int unsigned L0  = 5;
    localparam int unsigned NE0 = N0 * N0;
    localparam int unsigned B0  = (NE0 + L0 - 1) / L0;
    localparam int unsigned N1  = 3;
    localparam int unsigned L1  = 4;
    localparam int unsigned NE1 = N1 * N1;
    localparam int unsigned VW0 = NE0 * W;
    localparam int unsigned VW1 = NE1 * W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matriz_addsub_seq_if #(.N(N0), .W(W)) bus0 ();
    matriz_addsub_seq_if #(.N(N1), .W(W)) bus1 ();

    matriz_addsub_seq #(.N(N0), .W(W), .LANES(L0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    matriz_addsub_seq #(.N(N1), .W(W), .LANES(L1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checkOn     = 1'b0;

    task automatic check1(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkVec(input string name, input logic [VW0-1:0] act, input logic [VW0-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Element-wise signed arithmetic on plain integers
    function automatic logic [VW0-1:0] modelRes(input logic [VW0-1:0] a, input logic [VW0-1:0] b,
                                                input logic o, output bit ov);
        logic [VW0-1:0] r;
        int hi;
        int lo;
        hi = 2 ** (W - 1) - 1;
        lo = -(2 ** (W - 1));
        ov = 1'b0;
        r  = '0;
        for (int e = 0; e < int'(NE0); e++) begin
            int x;
            int y;
            int s;
            x = $signed(a[e*W +: W]);
            y = $signed(b[e*W +: W]);
            s = o ? (x - y) : (x + y);
            if (s > hi || s < lo) begin
                ov = 1'b1;
`ifdef MATRIZ_SAT_EN
                s = (s > hi) ? hi : lo;
`endif
            end
            r[e*W +: W] = W'(s);
        end
        return r;
    endfunction

    int             expBusy = 0;
    bit             expDone = 1'b0;
    bit             expOvf  = 1'b0;
    logic [VW0-1:0] expRes  = '0;
    logic [VW0-1:0] pendRes = '0;
    bit             pendOvf = 1'b0;

    // Model: accept in idle, BEATS busy cycles, one done cycle, then idle again
    always @(posedge clk) begin
        if (reset) begin
            expBusy = 0;
            expDone = 1'b0;
            expOvf  = 1'b0;
            expRes  = '0;
        end else if (expDone) begin
            expDone = 1'b0;
        end else if (expBusy > 0) begin
            expBusy--;
            if (expBusy == 0) begin
                expDone = 1'b1;
                expRes  = pendRes;
                expOvf  = pendOvf;
            end
        end else if (bus0.start) begin
            pendRes = modelRes(bus0.matrizA, bus0.matrizB, bus0.op, pendOvf);
            expBusy = int'(B0);
            expOvf  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            check1("busy", int'(bus0.busy), int'(expBusy > 0));
            check1("done", int'(bus0.done), int'(expDone));
            if (expBusy == 0) begin
                check1("overflow", int'(bus0.overflow), int'(expOvf));
                checkVec("result", bus0.matriz_resultante, expRes);
            end
        end
    end

    task automatic startOp(input logic [VW0-1:0] a, input logic [VW0-1:0] b, input logic o);
        bus0.matrizA = a;
        bus0.matrizB = b;
        bus0.op      = o;
        bus0.start   = 1'b1;
        @(negedge clk);
        bus0.start   = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (!bus0.done) begin
            if (cyc >= 40) begin
                check1("done_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [VW0-1:0] fill(input logic [W-1:0] v);
        logic [VW0-1:0] r;
        for (int e = 0; e < int'(NE0); e++) r[e*W +: W] = v;
        return r;
    endfunction

    initial begin
        int cyc;
        int busyCnt;
        int doneCnt;
        int firstDone;
        logic [VW0-1:0] va;
        logic [VW0-1:0] vb;
        logic [VW0-1:0] exp1;
        logic [W-1:0]   e0;

        reset = 1'b1;
        bus0.start = 1'b0; bus0.op = 1'b0; bus0.matrizA = '0; bus0.matrizB = '0;
        bus1.start = 1'b0; bus1.op = 1'b0; bus1.matrizA = '0; bus1.matrizB = '0;
        @(negedge clk);
        @(negedge clk);
        check1("reset_busy", int'(bus0.busy), 0);
        check1("reset_done", int'(bus0.done), 0);
        check1("reset_ovf", int'(bus0.overflow), 0);
        checkVec("reset_result", bus0.matriz_resultante, '0);
        reset   = 1'b0;
        checkOn = 1'b1;

        // 3 + 4 on every element
        startOp(fill(8'd3), fill(8'd4), OP_ADD);
        waitDone(cyc);
        check1("add_latency", cyc, 6);
        checkVec("add_result", bus0.matriz_resultante, fill(8'd7));
        check1("add_ovf", int'(bus0.overflow), 0);
        @(negedge clk);

        // -128 - 1 in element 0
        va = '0; vb = '0;
        va[W-1:0] = 8'h80;
        vb[W-1:0] = 8'h01;
        startOp(va, vb, OP_SUB);
        waitDone(cyc);
        e0 = bus0.matriz_resultante[W-1:0];
`ifdef MATRIZ_SAT_EN
        check1("sub_elem0", int'(e0), 32'h80);
`else
        check1("sub_elem0", int'(e0), 32'h7f);
`endif
        check1("sub_ovf", int'(bus0.overflow), 1);
        @(negedge clk);

        // Operands change right after start; overflow clears on accept
        va = '0; vb = '0;
        for (int e = 0; e < int'(NE0); e++) begin
            va[e*W +: W] = W'(e);
            vb[e*W +: W] = W'(2);
        end
        startOp(va, vb, OP_ADD);
        check1("ovf_cleared", int'(bus0.overflow), 0);
        bus0.matrizA = fill(8'h55);
        waitDone(cyc);
        exp1 = '0;
        for (int e = 0; e < int'(NE0); e++) exp1[e*W +: W] = W'(e + 2);
        checkVec("latched_result", bus0.matriz_resultante, exp1);
        @(negedge clk);

        // Start held high for 10 cycles
        bus0.matrizA = fill(8'd1); bus0.matrizB = fill(8'd1); bus0.op = OP_ADD;
        bus0.start = 1'b1;
        doneCnt = 0; firstDone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus0.done) begin
                doneCnt++;
                if (firstDone == 0) firstDone = k;
            end
            if (k == 7) check1("held_idle_c7", int'(bus0.busy), 0);
            if (k == 8) check1("held_accept_c8", int'(bus0.busy), 1);
        end
        bus0.start = 1'b0;
        check1("held_done_count", doneCnt, 1);
        check1("held_first_done", firstDone, 6);
        waitDone(cyc);
        @(negedge clk);

        // Reset during beat 2
        startOp(fill(8'd9), fill(8'd9), OP_ADD);
        @(negedge clk);
        reset = 1'b1;
        bus0.start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus0.start = 1'b0;
        check1("rst_busy", int'(bus0.busy), 0);
        check1("rst_done", int'(bus0.done), 0);
        checkVec("rst_result", bus0.matriz_resultante, '0);
        doneCnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus0.done) doneCnt++;
        end
        check1("rst_no_done", doneCnt, 0);

        // N=3, LANES=4 instance: three beats
        for (int e = 0; e < int'(NE1); e++) begin
            bus1.matrizA[e*W +: W] = W'(e);
            bus1.matrizB[e*W +: W] = W'(2 * e);
        end
        bus1.op = OP_ADD;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        busyCnt = 0; doneCnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus1.busy) busyCnt++;
            if (bus1.done) doneCnt++;
            @(negedge clk);
        end
        check1("n3_busy_cycles", busyCnt, 3);
        check1("n3_done_pulses", doneCnt, 1);
        exp1 = '0;
        for (int e = 0; e < int'(NE1); e++) exp1[e*W +: W] = W'(3 * e);
        checkVec("n3_result", {{(VW0-VW1){1'b0}}, bus1.matriz_resultante}, exp1);
        check1("n3_ovf", int'(bus1.overflow), 0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            reset      = ($urandom_range(149) == 0);
            bus0.start = ($urandom_range(2) == 0);
            bus0.op    = 1'($urandom);
            for (int e = 0; e < int'(NE0); e++) begin
                bus0.matrizA[e*W +: W] = W'($urandom);
                bus0.matrizB[e*W +: W] = W'($urandom);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        bus0.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
